// File: rtl/fp16_to_intn_stream.sv
// ---------------------------------------------------------------------------
// fp16_to_intn_stream
//
// Converts a stream of IEEE-754 binary16 values into signed INT_WIDTH-bit
// integers. Round-to-nearest-even, saturating to the integer range.
// Two registered stages:
//   stage 1: decode exponent and align the significand into an integer
//            magnitude plus round/sticky bits
//   stage 2: round, apply sign, clamp, and classify (sat/nan)
// Sticky saturation/NaN flags and a saturation event counter are updated
// only when an output beat is accepted downstream.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   in_valid_i/in_ready_o/fp16_i       input stream: {sign, exp[4:0], frac[9:0]}
//   out_valid_o/out_ready_i            output stream handshake
//   int_o, sat_o, nan_o                per-beat result and status
//   clear_flags_i                      synchronous clear of sticky status
//   sat_flag_o, nan_flag_o             sticky status of accepted beats
//   sat_count_o                        accepted saturated beats, holds at 0xFFFF
//
// INT_WIDTH == 1 uses the encoding bit 1 = +1, bit 0 = -1.
// ---------------------------------------------------------------------------
module fp16_to_intn_stream #(
    parameter int INT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [15:0]          fp16_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [INT_WIDTH-1:0] int_o,
    output logic                 sat_o,
    output logic                 nan_o,
    input  logic                 clear_flags_i,
    output logic                 sat_flag_o,
    output logic                 nan_flag_o,
    output logic [15:0]          sat_count_o
);

    localparam int MAX_I = (1 << (INT_WIDTH - 1)) - 1;
    localparam int MIN_I = -(1 << (INT_WIDTH - 1));
    localparam logic signed [19:0] MAX_V = 20'(MAX_I);
    localparam logic signed [19:0] MIN_V = 20'(MIN_I);

    // -----------------------------------------------------------------------
    // Handshake: a stage advances when it is empty or its consumer takes it.
    // -----------------------------------------------------------------------
    logic s1_valid;
    logic adv2;

    assign adv2       = !out_valid_o || out_ready_i;
    assign in_ready_o = !s1_valid || adv2;

    // -----------------------------------------------------------------------
    // Stage 1 decode (combinational)
    // -----------------------------------------------------------------------
    logic [4:0]  d_exp;
    logic [9:0]  d_frac;
    logic [10:0] d_sig;
    logic [4:0]  d_rshift;
    logic [21:0] d_align;
    logic [16:0] d_mag;
    logic        d_round;
    logic        d_sticky;
    logic        d_inf;
    logic        d_nan;

    assign d_exp  = fp16_i[14:10];
    assign d_frac = fp16_i[9:0];
    assign d_sig  = {1'b1, d_frac};

    // For 15 <= exp <= 25 the significand is shifted right by 25-exp. The
    // shifted-out bits land in d_align[10:0]: bit 10 is the round bit and the
    // rest feed sticky.
    assign d_rshift = 5'd25 - d_exp;
    assign d_align  = {d_sig, 11'b0} >> d_rshift;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else chain can leave a value held (latch).
    always_comb begin
        d_mag    = '0;
        d_round  = 1'b0;
        d_sticky = 1'b0;
        d_inf    = 1'b0;
        d_nan    = 1'b0;
        if (d_exp == 5'd31) begin
            d_inf = (d_frac == 10'd0);
            d_nan = (d_frac != 10'd0);
        end else if (d_exp != 5'd0 && d_exp <= 5'd13) begin
            // |x| < 0.5 but non-zero: only sticky survives
            d_sticky = 1'b1;
        end else if (d_exp == 5'd14) begin
            // 0.5 <= |x| < 1
            d_round  = 1'b1;
            d_sticky = |d_frac;
        end else if (d_exp >= 5'd15 && d_exp <= 5'd25) begin
            d_mag    = {6'b0, d_align[21:11]};
            d_round  = d_align[10];
            d_sticky = |d_align[9:0];
        end else if (d_exp >= 5'd26) begin
            // exact: the significand is shifted left, at most 65504
            d_mag = {6'b0, d_sig} << (d_exp - 5'd25);
        end
        // exp == 0 (zero / subnormal) keeps the all-zero defaults
    end

    // -----------------------------------------------------------------------
    // Stage 1 registers
    // -----------------------------------------------------------------------
    logic        s1_sign;
    logic [16:0] s1_mag;
    logic        s1_round;
    logic        s1_sticky;
    logic        s1_inf;
    logic        s1_nan;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge value of its sources, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_sign   <= 1'b0;
            s1_mag    <= '0;
            s1_round  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_inf    <= 1'b0;
            s1_nan    <= 1'b0;
        end else if (in_ready_o && in_valid_i) begin
            s1_sign   <= fp16_i[15];
            s1_mag    <= d_mag;
            s1_round  <= d_round;
            s1_sticky <= d_sticky;
            s1_inf    <= d_inf;
            s1_nan    <= d_nan;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 round / sign / saturate (combinational)
    // -----------------------------------------------------------------------
    logic [17:0]           r_mag;
    logic signed [19:0]    r_val;
    logic [INT_WIDTH-1:0]  n_int;
    logic                  n_sat;
    logic                  n_nan;

    // Round half to even: bump on round bit when above half or lsb is odd.
    assign r_mag = {1'b0, s1_mag} + 18'(s1_round && (s1_sticky || s1_mag[0]));
    assign r_val = s1_sign ? -$signed({2'b00, r_mag}) : $signed({2'b00, r_mag});

    always_comb begin
        n_int = r_val[INT_WIDTH-1:0];
        n_sat = 1'b0;
        n_nan = 1'b0;
        if (s1_nan) begin
            n_int = '0;
            n_nan = 1'b1;
        end else if (s1_inf) begin
            n_int = s1_sign ? MIN_V[INT_WIDTH-1:0] : MAX_V[INT_WIDTH-1:0];
            n_sat = 1'b1;
        end else if (r_val > MAX_V) begin
            n_int = MAX_V[INT_WIDTH-1:0];
            n_sat = 1'b1;
        end else if (r_val < MIN_V) begin
            n_int = MIN_V[INT_WIDTH-1:0];
            n_sat = 1'b1;
        end

        // One-bit lanes carry only +1/-1; anything else counts as clamped.
        if (INT_WIDTH == 1) begin
            n_int    = '0;
            n_int[0] = s1_nan ? 1'b1 : !s1_sign;
            n_sat    = !s1_nan && (s1_inf || r_mag != 18'd1);
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 registers (output)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
        end else if (adv2) begin
            out_valid_o <= s1_valid;
        end
    end

    // Data only loads with a real beat, so it stays stable while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            int_o <= '0;
            sat_o <= 1'b0;
            nan_o <= 1'b0;
        end else if (adv2 && s1_valid) begin
            int_o <= n_int;
            sat_o <= n_sat;
            nan_o <= n_nan;
        end
    end

    // -----------------------------------------------------------------------
    // Status: counts only beats taken downstream; clear wins over the event.
    // -----------------------------------------------------------------------
    logic out_accept;
    assign out_accept = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_flag_o  <= 1'b0;
            nan_flag_o  <= 1'b0;
            sat_count_o <= '0;
        end else if (clear_flags_i) begin
            sat_flag_o  <= 1'b0;
            nan_flag_o  <= 1'b0;
            sat_count_o <= '0;
        end else if (out_accept) begin
            sat_flag_o <= sat_flag_o || sat_o;
            nan_flag_o <= nan_flag_o || nan_o;
            if (sat_o && sat_count_o != 16'hFFFF) begin
                sat_count_o <= sat_count_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fp16_to_intn_stream.sv
// ---------------------------------------------------------------------------
// tb_fp16_to_intn_stream
//
// Scoreboard bench. Three instances: INT_WIDTH=4 (main stream, handshake,
// status, reset) and INT_WIDTH=16 / INT_WIDTH=1 sharing one input bus with
// the output always ready. Drivers push hand-computed expectations into
// queues on acceptance; monitors pop and compare on every accepted output.
// ---------------------------------------------------------------------------
module tb_fp16_to_intn_stream;

    typedef struct {
        logic [3:0] int_v;
        logic       sat;
        logic       nan;
        int         acc;
        bit         lat;
    } exp4_t;

    typedef struct {
        logic [15:0] i16;
        logic        s16;
        logic        i1;
        logic        s1;
    } expx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- INT_WIDTH = 4 instance ----------------
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [15:0] fp4;
    logic [3:0]  int4;
    logic        sat4, nan4, clr4, sat_flag4, nan_flag4;
    logic [15:0] cnt4;

    fp16_to_intn_stream #(.INT_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4), .fp16_i(fp4),
        .out_valid_o(out_valid4), .out_ready_i(out_ready4),
        .int_o(int4), .sat_o(sat4), .nan_o(nan4),
        .clear_flags_i(clr4), .sat_flag_o(sat_flag4), .nan_flag_o(nan_flag4),
        .sat_count_o(cnt4)
    );

    // ---------------- INT_WIDTH = 16 and 1 instances ----------------
    logic        in_valid_x, in_ready16, in_ready1, out_valid16, out_valid1;
    logic        out_ready_x, clr_x;
    logic [15:0] fp_x;
    logic [15:0] int16;
    logic [0:0]  int1;
    logic        sat16, nan16, sf16, nf16, sat1, nan1, sf1, nf1;
    logic [15:0] cnt16, cnt1;

    fp16_to_intn_stream #(.INT_WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid_x), .in_ready_o(in_ready16), .fp16_i(fp_x),
        .out_valid_o(out_valid16), .out_ready_i(out_ready_x),
        .int_o(int16), .sat_o(sat16), .nan_o(nan16),
        .clear_flags_i(clr_x), .sat_flag_o(sf16), .nan_flag_o(nf16),
        .sat_count_o(cnt16)
    );

    fp16_to_intn_stream #(.INT_WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid_x), .in_ready_o(in_ready1), .fp16_i(fp_x),
        .out_valid_o(out_valid1), .out_ready_i(out_ready_x),
        .int_o(int1), .sat_o(sat1), .nan_o(nan1),
        .clear_flags_i(clr_x), .sat_flag_o(sf1), .nan_flag_o(nf1),
        .sat_count_o(cnt1)
    );

    exp4_t q4[$];
    expx_t qx[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Drive one beat into the 4-bit instance; push expectation on acceptance.
    task automatic send4(input logic [15:0] fp, input logic [3:0] want,
                         input logic ws, input logic wn, input bit lat);
        int    guard;
        exp4_t e;
        guard = 0;
        @(negedge clk);
        in_valid4 = 1'b1;
        fp4       = fp;
        #1;
        while (!in_ready4 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready4) begin
            fail_now("input accept timeout");
        end else begin
            e.int_v = want; e.sat = ws; e.nan = wn; e.acc = cyc; e.lat = lat;
            @(posedge clk);
            q4.push_back(e);
        end
        #1 in_valid4 = 1'b0;
    endtask

    task automatic sendx(input logic [15:0] fp, input logic [15:0] w16, input logic ws16,
                         input logic w1, input logic ws1);
        expx_t e;
        @(negedge clk);
        in_valid_x = 1'b1;
        fp_x       = fp;
        #1;
        check("x in_ready", {in_ready16, in_ready1}, 2'b11);
        e.i16 = w16; e.s16 = ws16; e.i1 = w1; e.s1 = ws1;
        @(posedge clk);
        qx.push_back(e);
        #1 in_valid_x = 1'b0;
    endtask

    task automatic wait_drain4();
        int guard;
        guard = 0;
        while ((q4.size() != 0 || out_valid4) && guard < 200) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (q4.size() != 0) fail_now("drain timeout");
        // let the last accepted beat reach the status registers
        @(negedge clk);
        #2;
    endtask

    // ---------------- monitor: 4-bit instance ----------------
    exp4_t      m4;
    bit         held4 = 1'b0;
    logic [3:0] held_int;
    logic       held_sat, held_nan;

    always @(posedge rst) held4 = 1'b0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            held4 = 1'b0;
        end else begin
            if (held4) begin
                if (!out_valid4) begin
                    fail_now("out_valid dropped while stalled");
                end else begin
                    check("stall hold int", int4, held_int);
                    check("stall hold sat/nan", {sat4, nan4}, {held_sat, held_nan});
                end
            end
            held4 = 1'b0;
            if (out_valid4) begin
                if (out_ready4) begin
                    if (q4.size() == 0) begin
                        fail_now("unexpected output beat");
                    end else begin
                        m4 = q4.pop_front();
                        check("int_o", int4, m4.int_v);
                        check("sat_o", sat4, m4.sat);
                        check("nan_o", nan4, m4.nan);
                        if (m4.lat) check("latency", cyc - m4.acc, 2);
                    end
                end else begin
                    held4    = 1'b1;
                    held_int = int4;
                    held_sat = sat4;
                    held_nan = nan4;
                end
            end
        end
    end

    // ---------------- monitor: 16-bit and 1-bit instances ----------------
    expx_t mx;
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid16) begin
            check("w1 valid aligned", out_valid1, 1);
            if (qx.size() == 0) begin
                fail_now("unexpected x beat");
            end else begin
                mx = qx.pop_front();
                check("w16 int_o", int16, mx.i16);
                check("w16 sat_o", sat16, mx.s16);
                check("w1 int_o", int1, mx.i1);
                check("w1 sat_o", sat1, mx.s1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [15:0] bp_fp  [6];
    logic [3:0]  bp_int [6];
    bit          done;

    initial begin
        int guard;
        bp_fp  = '{16'h3C00, 16'h4000, 16'h4200, 16'hC400, 16'h4500, 16'hC600};
        bp_int = '{4'h1,     4'h2,     4'h3,     4'hC,     4'h5,     4'hA};
        in_valid4 = 1'b0; fp4 = '0; out_ready4 = 1'b1; clr4 = 1'b0;
        in_valid_x = 1'b0; fp_x = '0; out_ready_x = 1'b1; clr_x = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        check("reset out_valid", out_valid4, 0);
        check("reset int/sat/nan", {int4, sat4, nan4}, 0);
        check("reset flags", {sat_flag4, nan_flag4}, 0);
        check("reset sat_count", cnt4, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready after reset", in_ready4, 1);

        // ---- basic conversions, back to back, latency checked ----
        send4(16'h3C00, 4'h1, 1'b0, 1'b0, 1'b1);
        send4(16'hC000, 4'hE, 1'b0, 1'b0, 1'b1);
        send4(16'h3A00, 4'h1, 1'b0, 1'b0, 1'b1);
        send4(16'hB800, 4'h0, 1'b0, 1'b0, 1'b1);
        // ---- rounding ties ----
        send4(16'h4100, 4'h2, 1'b0, 1'b0, 1'b1);
        send4(16'h4300, 4'h4, 1'b0, 1'b0, 1'b1);
        send4(16'hC840, 4'h8, 1'b0, 1'b0, 1'b1);
        // ---- saturation and specials ----
        send4(16'h4800, 4'h7, 1'b1, 1'b0, 1'b1);
        send4(16'hC880, 4'h8, 1'b1, 1'b0, 1'b1);
        send4(16'h7C00, 4'h7, 1'b1, 1'b0, 1'b1);
        send4(16'hFC00, 4'h8, 1'b1, 1'b0, 1'b1);
        send4(16'h7E00, 4'h0, 1'b0, 1'b1, 1'b1);
        wait_drain4();
        check("sat_count after specials", cnt4, 4);
        check("sat_flag after specials", sat_flag4, 1);
        check("nan_flag after specials", nan_flag4, 1);

        // ---- clear during an accepted saturated beat ----
        send4(16'h4800, 4'h7, 1'b1, 1'b0, 1'b1);
        guard = 0;
        @(negedge clk);
        while (!out_valid4 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid4) fail_now("clear beat timeout");
        clr4 = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;
        #1;
        check("sat_count after clear", cnt4, 0);
        check("flags after clear", {sat_flag4, nan_flag4}, 0);

        // ---- backpressure: out_ready low for cycles 3..7 ----
        fork
            begin
                for (int i = 0; i < 6; i++) send4(bp_fp[i], bp_int[i], 1'b0, 1'b0, 1'b0);
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    out_ready4 = !(k >= 3 && k <= 7);
                    if (k == 6) begin
                        #1;
                        check("in_ready low when full", in_ready4, 0);
                        check("out_valid held when full", out_valid4, 1);
                    end
                end
                out_ready4 = 1'b1;
            end
        join
        wait_drain4();

        // ---- backpressure: random out_ready ----
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send4(bp_fp[i], bp_int[i], 1'b0, 1'b0, 1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready4 = 1'($urandom_range(0, 1));
                end
                out_ready4 = 1'b1;
            end
        join
        wait_drain4();

        // ---- INT_WIDTH = 16 and INT_WIDTH = 1 ----
        sendx(16'h7BFF, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        sendx(16'hF800, 16'h8000, 1'b0, 1'b0, 1'b1);
        sendx(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        sendx(16'hBC00, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        sendx(16'h4000, 16'h0002, 1'b0, 1'b1, 1'b1);
        guard = 0;
        while (qx.size() != 0 && guard < 50) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (qx.size() != 0) fail_now("x drain timeout");

        // ---- reset with two beats in flight ----
        out_ready4 = 1'b0;
        send4(16'h3C00, 4'h1, 1'b0, 1'b0, 1'b0);
        send4(16'h4000, 4'h2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("valid before reset", out_valid4, 1);
        #2 rst = 1'b1;
        #1;
        check("out_valid async reset", out_valid4, 0);
        q4.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready after mid-stream reset", in_ready4, 1);
        out_ready4 = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("no stale beat after reset", out_valid4, 0);
        check("sat_count after reset", cnt4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp16_to_intn_stream.md
# fp16_to_intn_stream

Streaming converter from IEEE-754 binary16 to a signed INT_WIDTH-bit integer. It is the decode-side counterpart of the intN→fp16 expansion used on the low-precision datapath, and re-quantizes fp16 results back into packed integer lanes. It has a 2-stage registered pipeline with valid/ready handshakes on both sides. Rounding is round-to-nearest-even, results saturate to the integer range, and the block keeps sticky saturation/NaN status plus a saturation event counter.

## Interface
- INT_WIDTH, default 4: output integer width, legal range 1..16.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when high together with in_valid_i.
- fp16_i  in  16  binary16 operand: {sign, exp[4:0], frac[9:0]}.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts output.
- int_o  out  INT_WIDTH  two's-complement result.
- sat_o  out  1  this beat was clamped (includes ±inf).
- nan_o  out  1  this beat's input was NaN.
- clear_flags_i  in  1  synchronous clear of sticky flags and counter.
- sat_flag_o  out  1  sticky: a saturated beat was accepted downstream.
- nan_flag_o  out  1  sticky: a NaN beat was accepted downstream.
- sat_count_o  out  16  count of accepted saturated beats, saturating at 0xFFFF.

## Operation
- Stage 1 (decode/align):
  - E = exp − 15; significand m = {1, frac}.
  - exp == 0 (zero/subnormal): magnitude 0, round and sticky bits 0.
  - E ≤ −2: magnitude 0, sticky 1.
  - E = −1: magnitude 0, round bit 1, sticky = |frac.
  - 0 ≤ E ≤ 10: integer = m >> (10−E); round = next bit below; sticky = OR of the remaining bits.
  - 11 ≤ E ≤ 15: integer = m << (E−10), exact. Use a 17-bit unsigned magnitude.
  - exp == 31: inf (frac == 0) or NaN.
- Stage 2 (round/sign/saturate):
  - Increment the magnitude if round & (sticky | lsb).
  - Negate if sign is set.
  - Clamp to [−2^(INT_WIDTH−1), 2^(INT_WIDTH−1)−1]. sat_o = 1 iff clamping changed the value.
  - +inf → max, −inf → min, both with sat_o = 1.
  - NaN → 0, nan_o = 1, sat_o = 0.
  - −0 and sign-negative values that round to 0 → 0.
- INT_WIDTH == 1 uses the encoding bit 1 = +1, bit 0 = −1:
  - int_o = ~sign for all non-NaN inputs, including ±0.
  - NaN → 1 with nan_o = 1.
  - sat_o = 1 iff the rounded value is not in {−1, +1}.
- Status, updated only on an accepted output beat (out_valid_o & out_ready_i):
  - sat_flag_o |= sat_o and nan_flag_o |= nan_o.
  - sat_count_o += sat_o, holding at 0xFFFF.
  - clear_flags_i has priority: in the same cycle it zeroes flags and counter, and that beat's event is discarded.

## Timing
- Reset values: all pipeline valids 0; out_valid_o, int_o, sat_o, nan_o, sat_flag_o, nan_flag_o and sat_count_o all 0.
- Reset mid-stream discards in-flight beats. in_ready_o is 1 in the first cycle after reset deassertion.
- Latency: 2 cycles from input acceptance to out_valid_o when unstalled. Throughput: 1 beat/cycle.
- Advance rules:
  - adv2 = !v2 | out_ready_i.
  - in_ready_o = !v1 | adv2.
  - The combinational path out_ready_i → in_ready_o is permitted.
- Output stability: while out_valid_o & !out_ready_i, int_o, sat_o and nan_o hold stable.
- out_valid_o never drops without acceptance.
- Registers load only on advance; no beat is dropped or duplicated; order is preserved.
- Full stall: both stages hold, in_ready_o = 0. Two beats are buffered, and the third input waits.
- Simultaneous accept-in and accept-out while full: both stages shift, still full.

## Test plan
- Basic conversions (INT_WIDTH=4, out_ready_i=1):
  - 0x3C00 → 0x1.
  - 0xC000 → 0xE.
  - 0x3A00 (0.75) → 0x1.
  - 0xB800 (−0.5) → 0x0.
  - Each appears exactly 2 cycles after acceptance.
- Rounding ties: 0x4100 (2.5) → 0x2, 0x4300 (3.5) → 0x4, 0xC840 (−8.5) → 0x8 with sat_o = 0.
- Saturation and specials:
  - 0x4800 (8.0) → 0x7 with sat_o.
  - 0xC880 (−9) → 0x8 with sat_o.
  - 0x7C00 → 0x7 with sat_o.
  - 0xFC00 → 0x8 with sat_o.
  - 0x7E00 → 0x0 with nan_o.
  - Afterwards sat_count_o = 4 and both sticky flags are 1.
  - Then clear_flags_i pulsed during an accepted saturated beat → flags 0, counter 0.
- Backpressure: stream 6 beats with out_ready_i low for cycles 3..7 → in_ready_o falls once 2 beats are held. All 6 outputs appear in order, each held stable while stalled. Re-run with out_ready_i randomized at 50%.
- INT_WIDTH=16: 0x7BFF (65504) → 0x7FFF with sat_o; 0xF800 (−32768) → 0x8000 with no sat. INT_WIDTH=1: 0x0000 → 1, 0xBC00 → 0, 0x4000 → 1 with sat_o.
- Reset asserted with 2 beats in flight → out_valid_o drops asynchronously, and no stale beat appears after release.
